// File: rtl/piso_bit_streamer_if.sv
// Word-in / bit-out handshake bundle for piso_bit_streamer.
// master = word producer and bit consumer side; slave = the streamer itself.
interface piso_bit_streamer_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     bit_out;
  logic                     bit_valid;
  logic                     bit_last;
  logic                     bit_ready;
  logic [$clog2(WIDTH)-1:0] bit_index;
  logic                     busy;

  modport master (
    output in_data, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last, bit_index, busy
  );

  modport slave (
    input  in_data, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last, bit_index, busy
  );
endinterface

// File: rtl/piso_bit_streamer.sv
// Parallel-in serial-out streamer: one WIDTH-bit word in, one bit per accepted cycle out.
// All outputs are flops; WIDTH must match the interface instance's WIDTH.
module piso_bit_streamer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               srst,
  piso_bit_streamer_if.slave io
);
  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             bit_last_q, bit_last_d;
  logic             bit_out_q, bit_out_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          shreg_d = io.in_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (io.bit_ready) begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear discards any partial word and overrides a same-cycle load or last transfer.
    if (rst || srst) begin
      state_d = IDLE;
      shreg_d = '0;
      idx_d   = '0;
    end

    // Outputs are decoded from next state so they come straight out of flops.
    in_ready_d  = (state_d == IDLE);
    bit_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    bit_last_d  = (state_d == SHIFT) && (idx_d == LAST_IDX);
    bit_out_d   = (state_d == SHIFT) && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    shreg_q     <= shreg_d;
    idx_q       <= idx_d;
    in_ready_q  <= in_ready_d;
    bit_valid_q <= bit_valid_d;
    busy_q      <= busy_d;
    bit_last_q  <= bit_last_d;
    bit_out_q   <= bit_out_d;
  end

  assign io.in_ready  = in_ready_q;
  assign io.bit_valid = bit_valid_q;
  assign io.busy      = busy_q;
  assign io.bit_last  = bit_last_q;
  assign io.bit_out   = bit_out_q;
  assign io.bit_index = idx_q;
endmodule

// File: tb/tb_piso_bit_streamer.sv
// Directed bench: LSB-first and MSB-first streamers driven with identical stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_piso_bit_streamer;
  logic        clk = 1'b0;
  logic        rst;
  logic        srst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        bit_ready;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  piso_bit_streamer_if #(.WIDTH(16)) if_l ();
  piso_bit_streamer_if #(.WIDTH(16)) if_m ();

  assign if_l.in_data   = in_data;
  assign if_l.in_valid  = in_valid;
  assign if_l.bit_ready = bit_ready;
  assign if_m.in_data   = in_data;
  assign if_m.in_valid  = in_valid;
  assign if_m.bit_ready = bit_ready;

  piso_bit_streamer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .srst (srst), .io (if_l.slave)
  );
  piso_bit_streamer #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .srst (srst), .io (if_m.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edges++;
  endtask

  task automatic load(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(if_l.in_ready), 32'd1);
    chk({tag, "_bit_valid"}, 32'(if_l.bit_valid), 32'd0);
    chk({tag, "_busy"},      32'(if_l.busy), 32'd0);
    chk({tag, "_bit_index"}, 32'(if_l.bit_index), 32'd0);
    chk({tag, "_bit_out"},   32'(if_l.bit_out), 32'd0);
  endtask

  // seq holds the expected emitted bits, seq[i] = i-th bit on the wire.
  task automatic stream(input string tag, input logic [15:0] seq, input bit msb);
    logic b, v, l;
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      b   = msb ? if_m.bit_out   : if_l.bit_out;
      v   = msb ? if_m.bit_valid : if_l.bit_valid;
      l   = msb ? if_m.bit_last  : if_l.bit_last;
      idx = msb ? if_m.bit_index : if_l.bit_index;
      chk($sformatf("%s_v%0d", tag, i),   32'(v),   32'd1);
      chk($sformatf("%s_b%0d", tag, i),   32'(b),   32'(seq[i]));
      chk($sformatf("%s_l%0d", tag, i),   32'(l),   32'(i == 15));
      chk($sformatf("%s_idx%0d", tag, i), 32'(idx), 32'(i));
      step();
    end
    chk({tag, "_done_in_ready"}, 32'(msb ? if_m.in_ready : if_l.in_ready), 32'd1);
    chk({tag, "_done_valid"},    32'(msb ? if_m.bit_valid : if_l.bit_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; srst = 1'b0; in_data = '0; in_valid = 1'b0; bit_ready = 1'b0;
    @(negedge clk);
    step();
    chk_idle("reset");
    chk("reset_bit_last", 32'(if_l.bit_last), 32'd0);
    rst = 1'b0;
    bit_ready = 1'b1;

    // 0xA5C3 LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    load(16'hA5C3);
    stream("lsb", 16'b1010_0101_1100_0011, 1'b0);

    // 0xA5C3 MSB first: 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 (seq[0] is the first bit)
    load(16'hA5C3);
    stream("msb", 16'b1100_0011_1010_0101, 1'b1);

    // Stall at bit 7 for three cycles
    edges = 0;
    load(16'h8001);
    for (int i = 0; i < 7; i++) step();
    chk("stall_pre_idx", 32'(if_l.bit_index), 32'd7);
    bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold_idx%0d", i),   32'(if_l.bit_index), 32'd7);
      chk($sformatf("stall_hold_out%0d", i),   32'(if_l.bit_out),   32'd0);
      chk($sformatf("stall_hold_valid%0d", i), 32'(if_l.bit_valid), 32'd1);
    end
    bit_ready = 1'b1;
    for (int i = 7; i < 15; i++) step();
    chk("stall_last_idx", 32'(if_l.bit_index), 32'd15);
    chk("stall_last_flag", 32'(if_l.bit_last), 32'd1);
    chk("stall_last_bit",  32'(if_l.bit_out),  32'd1);
    step();
    chk("stall_total_edges", 32'(edges), 32'd20);
    chk("stall_done_in_ready", 32'(if_l.in_ready), 32'd1);

    // Upstream holds 0x1234 valid while 0xFFFF streams
    load(16'hFFFF);
    in_data = 16'h1234; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("busy_in_ready%0d", i), 32'(if_l.in_ready), 32'd0);
      chk($sformatf("busy_bit%0d", i),      32'(if_l.bit_out),  32'd1);
      step();
    end
    chk("busy_idle_in_ready", 32'(if_l.in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    // 0x1234 LSB first: 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0
    stream("held", 16'b0001_0010_0011_0100, 1'b0);

    // rst after five transferred bits discards the word
    load(16'hFFFF);
    for (int i = 0; i < 5; i++) step();
    chk("rstmid_idx_before", 32'(if_l.bit_index), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rstmid");
    chk("rstmid_bit_last", 32'(if_l.bit_last), 32'd0);
    load(16'h0001);
    stream("after_rst", 16'h0001, 1'b0);

    // srst together with in_valid in IDLE
    in_data = 16'h5555; in_valid = 1'b1; srst = 1'b1;
    step();
    srst = 1'b0; in_valid = 1'b0;
    chk_idle("srst_load");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("srst_novalid%0d", i), 32'(if_l.bit_valid), 32'd0);
      chk($sformatf("srst_nobusy%0d", i),  32'(if_l.busy), 32'd0);
    end

    // srst during a stall mid-word
    load(16'hFFFF);
    for (int i = 0; i < 3; i++) step();
    bit_ready = 1'b0;
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    bit_ready = 1'b1;
    chk_idle("srst_stall");

    // srst coincident with the last-bit transfer
    load(16'hFFFF);
    for (int i = 0; i < 15; i++) step();
    chk("srst_last_flag", 32'(if_l.bit_last), 32'd1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk_idle("srst_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
